// File: rtl/control_useq.sv
// Microprogrammed control unit: writable table of control words with branch, loop and dispatch sequencing.
// Latency: zero-cycle control word; o_signal follows upc combinationally, and upc advances once per RUN cycle.
// Backpressure: none on the datapath side; table writes in RUN are dropped and flagged on wr_err.
// Optional single-step mode is built in when CONTROL_USEQ_STEP_EN is defined.
module control_useq #(
    parameter int CW_W   = 16,
    parameter int ADDR_W = 6,
    parameter int NFLAGS = 3,
    parameter int CNT_W  = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NFLAGS-1:0]          flags,
    input  logic                       start,
    input  logic                       prog_we,
    input  logic [ADDR_W-1:0]          prog_addr,
    input  logic [CW_W+ADDR_W+6-1:0]   prog_data,
`ifdef CONTROL_USEQ_STEP_EN
    input  logic                       step_mode,
    input  logic                       step,
`endif
    output logic [CW_W-1:0]            o_signal,
    output logic                       busy,
    output logic                       done,
    output logic [ADDR_W-1:0]          upc,
    output logic                       wr_err
);

    localparam int IW    = CW_W + ADDR_W + 6;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_SEQ  = 3'd0,
        OP_JMP  = 3'd1,
        OP_BR   = 3'd2,
        OP_LOOP = 3'd3,
        OP_LDC  = 3'd4,
        OP_DISP = 3'd5,
        OP_HALT = 3'd6,
        OP_RSVD = 3'd7
    } op_t;

    // Microprogram storage; contents are deliberately not reset.
    logic [IW-1:0]     r_mem [DEPTH];

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_upc;
    logic [ADDR_W-1:0] w_upc_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_wr_err;

    logic [IW-1:0]     w_instr;
    logic [CW_W-1:0]   w_ctrl;
    op_t               w_op;
    logic [1:0]        w_csel;
    logic              w_pol;
    logic [ADDR_W-1:0] w_target;
    logic [3:0]        w_flags_ext;
    logic              w_cond;
    logic              w_adv;
    logic [ADDR_W-1:0] w_upc_inc;
    logic [ADDR_W-1:0] w_disp;

    // Field decode of the current microinstruction (combinational table read).
    assign w_instr   = r_mem[r_upc];
    assign w_ctrl    = w_instr[IW-1 -: CW_W];
    assign w_op      = op_t'(w_instr[ADDR_W+5 -: 3]);
    assign w_csel    = w_instr[ADDR_W+2 -: 2];
    assign w_pol     = w_instr[ADDR_W];
    assign w_target  = w_instr[ADDR_W-1:0];
    assign w_upc_inc = r_upc + ADDR_W'(1);
    assign w_disp    = w_target + ADDR_W'(r_cnt);

`ifdef CONTROL_USEQ_STEP_EN
    assign w_adv = !step_mode || step;
`else
    assign w_adv = 1'b1;
`endif

    // Flag selects beyond NFLAGS read as constant 1 (unconditional true).
    always_comb begin
        w_flags_ext = 4'b1111;
        for (int i = 0; i < NFLAGS; i++) begin
            w_flags_ext[i] = flags[i];
        end
    end

    assign w_cond = w_flags_ext[w_csel] ^ w_pol;

    // Next-state / sequencing decision.
    always_comb begin
        w_state_nxt = r_state;
        w_upc_nxt   = r_upc;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_upc_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            end
            S_RUN: begin
                if (w_adv) begin
                    case (w_op)
                        OP_SEQ:  w_upc_nxt = w_upc_inc;
                        OP_JMP:  w_upc_nxt = w_target;
                        OP_BR:   w_upc_nxt = w_cond ? w_target : w_upc_inc;
                        OP_LOOP: begin
                            if (r_cnt != '0) begin
                                w_cnt_nxt = r_cnt - CNT_W'(1);
                                w_upc_nxt = w_target;
                            end else begin
                                w_upc_nxt = w_upc_inc;
                            end
                        end
                        OP_LDC: begin
                            w_cnt_nxt = w_target[CNT_W-1:0];
                            w_upc_nxt = w_upc_inc;
                        end
                        OP_DISP: begin
                            w_upc_nxt = w_disp;
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                        default: w_state_nxt = S_HALT;
                    endcase
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Sequencer state registers and write-reject pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_upc    <= '0;
            r_cnt    <= '0;
            r_wr_err <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_upc    <= w_upc_nxt;
            r_cnt    <= w_cnt_nxt;
            r_wr_err <= prog_we && (r_state == S_RUN);
        end
    end

    // Table write port; only open while the sequencer is not running.
    always_ff @(posedge clk) begin
        if (prog_we && (r_state != S_RUN)) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    assign o_signal = (r_state == S_RUN) ? w_ctrl : '0;
    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_HALT);
    assign upc      = r_upc;
    assign wr_err   = r_wr_err;

endmodule

// File: tb/tb_control_useq.sv
module tb_control_useq;

    localparam int CW_W   = 16;
    localparam int ADDR_W = 6;
    localparam int NFLAGS = 3;
    localparam int CNT_W  = 3;
    localparam int IW     = CW_W + ADDR_W + 6;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int CMOD   = 2 ** CNT_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NFLAGS-1:0] flags = '0;
    logic              start = 1'b0;
    logic              prog_we = 1'b0;
    logic [ADDR_W-1:0] prog_addr = '0;
    logic [IW-1:0]     prog_data = '0;
`ifdef CONTROL_USEQ_STEP_EN
    logic              step_mode = 1'b0;
    logic              step = 1'b0;
`endif
    logic [CW_W-1:0]   o_signal;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] upc;
    logic              wr_err;

    control_useq #(.CW_W(CW_W), .ADDR_W(ADDR_W), .NFLAGS(NFLAGS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flags(flags), .start(start),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
`ifdef CONTROL_USEQ_STEP_EN
        .step_mode(step_mode), .step(step),
`endif
        .o_signal(o_signal), .busy(busy), .done(done), .upc(upc), .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: 0 = idle, 1 = run, 2 = halted
    int            m_state;
    int            m_upc;
    int            m_cnt;
    bit            m_wr_err;
    logic [IW-1:0] m_mem [DEPTH];

    function automatic logic [IW-1:0] mk(int ctrl, int op, int csel, int pol, int tgt);
        return {CW_W'(ctrl), 3'(op), 2'(csel), 1'(pol), ADDR_W'(tgt)};
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_upc = 0; m_cnt = 0; m_wr_err = 0;
    endtask

    task automatic check_model();
        logic [CW_W-1:0] exp_sig;
        exp_sig = (m_state == 1) ? m_mem[m_upc][IW-1 -: CW_W] : '0;
        chk("o_signal", 64'(o_signal), 64'(exp_sig));
        chk("busy", 64'(busy), 64'(m_state == 1));
        chk("done", 64'(done), 64'(m_state == 2));
        chk("upc", 64'(upc), 64'(m_upc));
        chk("wr_err", 64'(wr_err), 64'(m_wr_err));
    endtask

    // Model advance for one rising edge using the currently driven inputs.
    task automatic model_edge();
        bit accept_wr, reject_wr, adv, c;
        int w, op, csel, pol, tgt;
        accept_wr = prog_we && (m_state != 1);
        reject_wr = prog_we && (m_state == 1);
        if (m_state == 1) begin
            adv = 1;
`ifdef CONTROL_USEQ_STEP_EN
            adv = !step_mode || step;
`endif
            if (adv) begin
                w    = int'(m_mem[m_upc][ADDR_W+5:0]);
                tgt  = w % DEPTH;
                pol  = (w / DEPTH) % 2;
                csel = (w / (DEPTH * 2)) % 4;
                op   = (w / (DEPTH * 8)) % 8;
                c    = ((csel < NFLAGS) ? ((int'(flags) >> csel) & 1) : 1) ^ pol;
                case (op)
                    0: m_upc = (m_upc + 1) % DEPTH;
                    1: m_upc = tgt;
                    2: m_upc = c ? tgt : (m_upc + 1) % DEPTH;
                    3: if (m_cnt != 0) begin m_cnt = m_cnt - 1; m_upc = tgt; end
                       else m_upc = (m_upc + 1) % DEPTH;
                    4: begin m_cnt = tgt % CMOD; m_upc = (m_upc + 1) % DEPTH; end
                    5: begin m_upc = (tgt + m_cnt) % DEPTH; m_cnt = (m_cnt + 1) % CMOD; end
                    default: m_state = 2;
                endcase
            end
        end else if (start) begin
            m_state = 1; m_upc = 0; m_cnt = 0;
        end
        if (accept_wr) m_mem[prog_addr] = prog_data;
        m_wr_err = reject_wr;
    endtask

    task automatic cyc();
        #2;
        check_model();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(int addr, logic [IW-1:0] data);
        prog_we = 1; prog_addr = ADDR_W'(addr); prog_data = data;
        cyc();
        prog_we = 0;
    endtask

    task automatic do_reset();
        #2;
        rst = 0;
        #1;
        model_reset();
        check_model();
        @(posedge clk);
        #1;
        check_model();
        rst = 1;
    endtask

    // Pulse start, then run until the model leaves RUN; counts DUT cycles spent at 'watch'.
    task automatic run_prog(int max, int watch, output int hits);
        int n;
        hits = 0;
        start = 1; cyc(); start = 0;
        n = 0;
        while (m_state == 1 && n < max) begin
            if (busy && int'(upc) == watch) hits++;
            cyc();
            n++;
        end
        if (n >= max) chk("run_timeout", 64'(1), 64'(0));
    endtask

    initial begin
        int hits;
        int seq_exp [7];

        #1;
        do_reset();
        chk("rst_upc", 64'(upc), 64'(0));
        chk("rst_done", 64'(done), 64'(0));

        // Fill the whole table with HALT so every address has a defined value.
        for (int a = 0; a < DEPTH; a++) wr(a, mk($urandom_range(0, 65535), 6, 0, 0, 0));

        // Linear run
        wr(0, mk(16'h4200, 0, 0, 0, 0));
        wr(1, mk(16'h8204, 0, 0, 0, 0));
        wr(2, mk(16'hA201, 0, 0, 0, 0));
        wr(3, mk(16'h0000, 6, 0, 0, 0));
        start = 1; cyc(); start = 0;
        chk("lin_w0", 64'(o_signal), 64'h4200);
        cyc();
        chk("lin_w1", 64'(o_signal), 64'h8204);
        cyc();
        chk("lin_w2", 64'(o_signal), 64'hA201);
        cyc();
        cyc();
        chk("lin_done", 64'(done), 64'(1));
        chk("lin_sig0", 64'(o_signal), 64'(0));
        cyc();
        chk("halt_hold", 64'(done), 64'(1));

        // Branch on neg flag, both polarities
        wr(0, mk(16'h0101, 2, 2, 0, 10));
        wr(1, mk(16'h0001, 6, 0, 0, 0));
        wr(10, mk(16'h000A, 6, 0, 0, 0));
        for (int k = 0; k < 4; k++) begin
            int pol;
            pol = k / 2;
            flags = (k % 2 == 0) ? 3'b100 : 3'b000;
            wr(0, mk(16'h0101, 2, 2, pol, 10));
            start = 1; cyc(); start = 0;
            cyc();
            chk("br_upc", 64'(upc), 64'((((k % 2) == 0) ^ (pol == 1)) ? 10 : 1));
            cyc(); cyc();
        end
        flags = '0;

        // Counted loop: LOOP at addr1 executes 4 times
        wr(0, mk(16'h0010, 4, 0, 0, 3));
        wr(1, mk(16'h0020, 3, 0, 0, 1));
        wr(2, mk(16'h0030, 6, 0, 0, 0));
        run_prog(40, 1, hits);
        chk("loop_count", 64'(hits), 64'(4));

        // Dispatch, including counter wrap
        wr(0, mk(16'h0001, 4, 0, 0, 2));
        wr(1, mk(16'h0002, 5, 0, 0, 8));
        wr(10, mk(16'h0003, 5, 0, 0, 20));
        wr(23, mk(16'h0004, 4, 0, 0, 7));
        wr(24, mk(16'h0005, 5, 0, 0, 8));
        wr(15, mk(16'h0006, 5, 0, 0, 30));
        wr(30, mk(16'h0007, 6, 0, 0, 0));
        seq_exp = '{0, 1, 10, 23, 24, 15, 30};
        start = 1; cyc(); start = 0;
        for (int i = 0; i < 7; i++) begin
            chk("disp_upc", 64'(upc), 64'(seq_exp[i]));
            cyc();
        end
        chk("disp_done", 64'(done), 64'(1));

        // Write while running is rejected with a single-cycle wr_err
        wr(0, mk(16'h1111, 1, 0, 0, 0));
        start = 1; cyc(); start = 0;
        cyc();
        prog_we = 1; prog_addr = 0; prog_data = mk(16'hDEAD, 6, 0, 0, 0);
        cyc();
        prog_we = 0;
        chk("wr_err_hi", 64'(wr_err), 64'(1));
        cyc();
        chk("wr_err_lo", 64'(wr_err), 64'(0));
        chk("wr_kept", 64'(o_signal), 64'h1111);

        // Reset mid-RUN at upc=5
        for (int a = 0; a < 5; a++) wr(a, mk(16'h0100 + a, 0, 0, 0, 0));
        do_reset();
        for (int a = 0; a < 5; a++) wr(a, mk(16'h0100 + a, 0, 0, 0, 0));
        wr(5, mk(16'h0105, 1, 0, 0, 5));
        start = 1; cyc(); start = 0;
        for (int n = 0; n < 20 && upc != 5; n++) cyc();
        chk("pre_rst_upc", 64'(upc), 64'(5));
        do_reset();
        chk("mid_rst_upc", 64'(upc), 64'(0));
        chk("mid_rst_sig", 64'(o_signal), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        cyc(); cyc();

        // Write and start in the same IDLE cycle
        prog_we = 1; prog_addr = 0; prog_data = mk(16'h5A5A, 6, 0, 0, 0); start = 1;
        cyc();
        prog_we = 0; start = 0;
        chk("we_start_sig", 64'(o_signal), 64'h5A5A);
        cyc();

`ifdef CONTROL_USEQ_STEP_EN
        // Single-step: step pulsed every third cycle
        do_reset();
        for (int a = 0; a < 8; a++) wr(a, mk(16'h0200 + a, 0, 0, 0, 0));
        wr(8, mk(16'h0208, 6, 0, 0, 0));
        step_mode = 1;
        start = 1; cyc(); start = 0;
        for (int n = 0; n < 12; n++) begin
            step = (n % 3 == 2);
            cyc();
        end
        step = 0;
        chk("step_upc", 64'(upc), 64'(4));
        step_mode = 0;
        do_reset();
`endif

        // Randomized programs and traffic against the model
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int a = 0; a < DEPTH; a++)
                wr(a, mk($urandom_range(0, 65535), $urandom_range(0, 7), $urandom_range(0, 3),
                         $urandom_range(0, 1), $urandom_range(0, DEPTH - 1)));
            start = 1; cyc(); start = 0;
            for (int n = 0; n < 250; n++) begin
                flags     = NFLAGS'($urandom);
                start     = ($urandom_range(0, 15) == 0);
                prog_we   = ($urandom_range(0, 11) == 0);
                prog_addr = ADDR_W'($urandom);
                prog_data = IW'({$urandom, $urandom});
`ifdef CONTROL_USEQ_STEP_EN
                step_mode = ($urandom_range(0, 3) == 0);
                step      = $urandom_range(0, 1) == 1;
`endif
                cyc();
            end
            start = 0; prog_we = 0;
        end
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_useq.md
Name: control_useq

Overview:
- Parametrised microprogrammed control unit. It is the generalised successor of the project's hard-wired control FSMs.
- A writable microprogram table holds one control word per step, plus sequencing fields: branch on datapath flags, counted loops, and pass dispatch.
- It drives the datapath control bus (ALU op, mux selects, register select, write enable) from the current microinstruction.
- Sits between the datapath flag outputs and the datapath control inputs.

Parameters:
- CW_W, 16: control word width (o_signal width).
- ADDR_W, 6: microprogram address width; depth = 2**ADDR_W.
- NFLAGS, 3: number of datapath condition flags (1..4).
- CNT_W, 3: pass/loop counter width (CNT_W <= ADDR_W).

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: asynchronous reset, active-low.
- flags, in, NFLAGS: datapath condition flags (e.g. mayor, zero, neg).
- start, in, 1: begin execution at address 0.
- prog_we, in, 1: microprogram write strobe.
- prog_addr, in, ADDR_W: microprogram write address.
- prog_data, in, IW: microinstruction, where IW = CW_W+ADDR_W+6.
- o_signal, out, CW_W: control word to the datapath.
- busy, out, 1: sequencer in RUN.
- done, out, 1: sequencer in HALT.
- upc, out, ADDR_W: current microprogram counter (debug).
- wr_err, out, 1: one-cycle pulse when a write is rejected.

Behaviour:
- Microinstruction fields, MSB to LSB:
  - ctrl[CW_W]
  - op[3]
  - csel[2]
  - pol[1]
  - target[ADDR_W]
- Condition: cond = (csel < NFLAGS ? flags[csel] : 1) XOR pol. Flags are sampled combinationally in the cycle the instruction is current.
- Table read is combinational from upc. Writes are registered on clk. Table contents are not reset.
- States:
  - IDLE: reset state. start -> RUN with upc=0 and cnt=0.
  - RUN: executes one microinstruction per cycle.
  - HALT: start -> RUN with upc=0 and cnt=0; otherwise HALT is held.
- Reset (any time, including mid-RUN): state=IDLE, upc=0, cnt=0, o_signal=0, busy=0, done=0, wr_err=0.
- o_signal = ctrl of mem[upc] while in RUN; all zeros in IDLE and HALT. No pipeline: the control word takes effect the same cycle upc changes.
- Ops (next upc is applied at the clock edge):
  - 0 SEQ: upc+1, wrapping from 2**ADDR_W-1 to 0.
  - 1 JMP: target.
  - 2 BR: cond ? target : upc+1.
  - 3 LOOP: if cnt != 0, then cnt <= cnt-1 and jump to target; else fall through to upc+1 with cnt held at 0.
  - 4 LDC: cnt <= target[CNT_W-1:0]; upc+1.
  - 5 DISP: upc <= (target + cnt) mod 2**ADDR_W; cnt <= cnt+1 (wraps).
  - 6 HALT: state -> HALT. o_signal is 0 from the next cycle.
  - 7 reserved: executes as HALT.
- busy = (state==RUN). done = (state==HALT).
- start while in RUN is ignored.
- prog_we is accepted only when not in RUN. In RUN the write is dropped and wr_err pulses high the next cycle.
- prog_we and start in the same cycle from IDLE: the write completes, and RUN begins the next cycle reading the updated table.

Optional Feature:
- Macro CONTROL_USEQ_STEP_EN.
- When defined:
  - Adds inputs step_mode (1) and step (1).
  - With step_mode=1 in RUN, upc/cnt/state update only in cycles where step=1. o_signal holds the current control word between steps.
  - With step_mode=0, behaviour is identical to the undefined case.
- When undefined: no ports are added, and the sequencer advances every cycle in RUN.

Test Plan:
- Reset/idle: rst=0 mid-RUN at upc=5 -> next cycle upc=0, o_signal=0, busy=0, done=0. Outputs stay there until start.
- Linear run: program addr0..2 = SEQ with ctrl 0x4200, 0x8204, 0xA201, then addr3 = HALT; pulse start -> o_signal shows 0x4200, 0x8204, 0xA201 on consecutive cycles, then done=1 and o_signal=0.
- Branch: addr0 = BR with csel=2 (neg), pol=0, target=10. With flags=3'b100 the next upc is 10; with flags=0 the next upc is 1. With pol=1 the outcome inverts.
- Loop: LDC target=3, then a LOOP back to itself -> the LOOP instruction is executed 4 times, cnt reaches 0, then upc falls through.
- Dispatch: cnt=2, DISP target=8 -> upc=10 and cnt=3. With CNT_W=3 and cnt=7, DISP gives upc=target+7 and cnt wraps to 0.
- Write rules: prog_we in RUN -> table unchanged and wr_err=1 for exactly one cycle. prog_we+start together in IDLE -> the first RUN cycle shows the new ctrl. Under CONTROL_USEQ_STEP_EN with step_mode=1 and step pulsed every 3rd cycle, upc advances once per pulse.
